menu_nav: RTL and testbench
===========================

// Module: menu_nav
// PURPOSE
//  Front-end controller for the main menu state machine: conditions raw board buttons and
//  drives the menu selection plus clean single-cycle button events into the menu state
//  machine, which switches between the menu (state 0), the selected item and side screens 5/6.
//  Owns the menu cursor (selected item 1..NUM_ITEMS) with wrap-around and hold-to-repeat.
//  Guarantees at most one button event per clock so downstream state updates never race.
// PARAMETERS
//  NUM_ITEMS       4        selectable items, cursor range 1..NUM_ITEMS; legal 2..4 (5, 6 reserved)
//  DEBOUNCE_CYCLES 250000   consecutive stable samples needed to accept a level change (2.5 ms @ 100 MHz)
//  REPEAT_CYCLES   30000000 U/D held this long (debounced) -> repeat step, then every REPEAT_CYCLES
// PORTS
//  clk         in   1  system clock, single domain
//  rst         in   1  synchronous reset, active-high
//  btnU        in   1  raw async button: cursor up
//  btnD        in   1  raw async button: cursor down
//  btnC        in   1  raw async button: select / back
//  btnL        in   1  raw async button: left screen / back
//  btnR        in   1  raw async button: right screen / back
//  active      in   1  1 = menu displayed (downstream state == 0); gates cursor movement only
//  menu_state  out  3  current cursor item, 1..NUM_ITEMS
//  c_pulse     out  1  one-cycle btnC press event
//  l_pulse     out  1  one-cycle btnL press event
//  r_pulse     out  1  one-cycle btnR press event
//  move_pulse  out  1  one-cycle strobe, high in the cycle after menu_state changed
// BEHAVIOUR
//  Reset: menu_state=1; all pulses 0; debounced levels 0; debounce/repeat counters 0.
//  Per button: 2-flop synchroniser -> debouncer. Debounced level flips on the edge where the
//   synchronised sample has differed from it for DEBOUNCE_CYCLES consecutive cycles; any
//   agreeing sample clears the counter. Press event = debounced 0->1, registered.
//  Latency: raw input stable from cycle N -> event/pulse high in cycle N+2+DEBOUNCE_CYCLES+1.
//   Release generates no event.
//  Arbitration: per cycle, fixed priority C > L > R > U > D; only the winner acts;
//   losing events of that cycle are discarded (not queued). At most one of
//   c_pulse/l_pulse/r_pulse/move_pulse is high in any cycle.
//  Cursor (only when active=1): D: item+1, NUM_ITEMS wraps to 1. U: item-1, 1 wraps to NUM_ITEMS.
//   active=0: U/D events and repeats discarded, menu_state held. C/L/R pass through regardless.
//  Repeat: while exactly one of U/D is debounced-high and active=1, repeat counter runs; at
//   REPEAT_CYCLES a repeat event is raised and the counter restarts. Counter clears on release,
//   active=0, or both U and D high (both high -> no repeats). Repeats are arbitrated as U/D events.
//  move_pulse asserts in the cycle after every menu_state update (also on wrap).
//  Reset mid-operation: all state returns to reset values; a button still held when rst drops
//   is treated as a new press and emits one event after the normal debounce latency.
//  menu_state never leaves 1..NUM_ITEMS; counters sized $clog2(param+1), no overflow.
// STRUCTURE
//  menu_pkg: button index constants (BTN_C..BTN_D), priority order, downstream state codes
//   (ST_MENU=0, ST_RIGHT=5, ST_LEFT=6), MAX_ITEMS=4.
//  Sub-module btn_debounce (sync + debounce counter + rising-edge detect, params
//   DEBOUNCE_CYCLES), instantiated 5x; arbiter, cursor and repeat logic in menu_nav.
// TESTING  (bench: NUM_ITEMS=4, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10)
//  1 rst high 3 cycles, buttons low -> menu_state=1, all pulses 0 throughout.
//  2 active=1; btnD toggles every 2 cycles x3 then held high from cycle N -> single
//    move_pulse at N+8 (menu_state 1->2 at N+7), no other events.
//  3 active=1; four clean btnD presses -> menu_state 2,3,4,1; then one btnU press -> 4.
//  4 btnC and btnU rise in same cycle -> one c_pulse only; menu_state unchanged, no move_pulse.
//  5 active=1; btnD held 25 cycles past debounce -> steps at t, t+10, t+20: 1->2->3->4.
//  6 active=0: btnU/btnD presses -> menu_state unchanged; btnR -> one r_pulse; btnC held
//    across a rst pulse -> one c_pulse 7 cycles after rst deasserts.

Source files
------------

// File: rtl/menu_pkg.sv
// Shared constants and helpers for the main-menu button front end.
package menu_pkg;

   localparam int unsigned NUM_BTNS  = 5;
   localparam int unsigned BTN_C     = 0;
   localparam int unsigned BTN_L     = 1;
   localparam int unsigned BTN_R     = 2;
   localparam int unsigned BTN_U     = 3;
   localparam int unsigned BTN_D     = 4;
   localparam int unsigned MAX_ITEMS = 4;
   localparam int unsigned ITEM_W    = 3;

   // Downstream menu state machine codes.
   typedef enum logic [2:0] {
      ST_MENU  = 3'd0,
      ST_RIGHT = 3'd5,
      ST_LEFT  = 3'd6
   } menu_state_e;

   typedef enum logic [2:0] {
      EV_NONE = 3'd0,
      EV_C    = 3'd1,
      EV_L    = 3'd2,
      EV_R    = 3'd3,
      EV_U    = 3'd4,
      EV_D    = 3'd5
   } btn_ev_e;

   // Fixed priority C > L > R > U > D; exactly one winner per cycle.
   function automatic btn_ev_e arbitrate(input logic [NUM_BTNS-1:0] ev);
      btn_ev_e win;
      win = EV_NONE;
      if (ev[BTN_C])      win = EV_C;
      else if (ev[BTN_L]) win = EV_L;
      else if (ev[BTN_R]) win = EV_R;
      else if (ev[BTN_U]) win = EV_U;
      else if (ev[BTN_D]) win = EV_D;
      return win;
   endfunction

   // Cursor step with wrap-around inside 1..num_items.
   function automatic logic [ITEM_W-1:0] step_item(input logic [ITEM_W-1:0] item,
                                                   input logic              up,
                                                   input logic [ITEM_W-1:0] num_items);
      logic [ITEM_W-1:0] nxt;
      if (up) nxt = (item <= ITEM_W'(1)) ? num_items : item - ITEM_W'(1);
      else    nxt = (item >= num_items) ? ITEM_W'(1) : item + ITEM_W'(1);
      return nxt;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: two-flop synchroniser, stability-count debouncer and
// registered press (debounced rising edge) strobe.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_press;

   // Level flips on the edge closing the last of DEBOUNCE_CYCLES disagreeing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
            r_press <= r_sync2;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/menu_nav.sv
// Main-menu front end: debounced buttons, single-winner event arbitration,
// cursor over 1..NUM_ITEMS with wrap-around and hold-to-repeat.
module menu_nav
   import menu_pkg::*;
#(
   parameter int unsigned NUM_ITEMS       = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned REPEAT_CYCLES   = 30000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btnU,
   input  logic       btnD,
   input  logic       btnC,
   input  logic       btnL,
   input  logic       btnR,
   input  logic       active,
   output logic [2:0] menu_state,
   output logic       c_pulse,
   output logic       l_pulse,
   output logic       r_pulse,
   output logic       move_pulse
);

   localparam int unsigned       REP_W     = $clog2(REPEAT_CYCLES + 1);
   localparam logic [ITEM_W-1:0] LAST_ITEM = ITEM_W'(NUM_ITEMS);

   logic [NUM_BTNS-1:0] w_raw;
   logic [NUM_BTNS-1:0] w_level;
   logic [NUM_BTNS-1:0] w_press;
   logic [NUM_BTNS-1:0] w_ev;
   logic                w_unused_levels;
   logic                w_rep_run;
   btn_ev_e             w_win;

   logic [REP_W-1:0]    r_rep_cnt;
   logic                r_rep_u;
   logic                r_rep_d;
   logic [ITEM_W-1:0]   r_item;
   logic                r_moved;
   logic                r_c;
   logic                r_l;
   logic                r_r;
   logic                r_move;

   assign w_raw[BTN_C] = btnC;
   assign w_raw[BTN_L] = btnL;
   assign w_raw[BTN_R] = btnR;
   assign w_raw[BTN_U] = btnU;
   assign w_raw[BTN_D] = btnD;

   for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .rst    (rst),
         .i_btn  (w_raw[gi]),
         .o_level(w_level[gi]),
         .o_press(w_press[gi])
      );
   end

   // Only the U/D levels feed the repeat logic.
   assign w_unused_levels = ^{w_level[BTN_C], w_level[BTN_L], w_level[BTN_R]};

   assign w_rep_run = active & (w_level[BTN_U] ^ w_level[BTN_D]);

   // Hold-to-repeat: a registered U/D event every REPEAT_CYCLES of a single held key.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rep_cnt <= '0;
         r_rep_u   <= 1'b0;
         r_rep_d   <= 1'b0;
      end else begin
         r_rep_u <= 1'b0;
         r_rep_d <= 1'b0;
         if (!w_rep_run) begin
            r_rep_cnt <= '0;
         end else if (r_rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
            r_rep_cnt <= '0;
            r_rep_u   <= w_level[BTN_U];
            r_rep_d   <= w_level[BTN_D];
         end else begin
            r_rep_cnt <= r_rep_cnt + REP_W'(1);
         end
      end
   end

   // The cycle after a cursor step is reserved for move_pulse, so nothing else may win it.
   always_comb begin
      w_ev        = w_press;
      w_ev[BTN_U] = w_press[BTN_U] | r_rep_u;
      w_ev[BTN_D] = w_press[BTN_D] | r_rep_d;
      if (!active) begin
         w_ev[BTN_U] = 1'b0;
         w_ev[BTN_D] = 1'b0;
      end
      if (r_moved) w_ev = '0;
   end

   assign w_win = arbitrate(w_ev);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_item  <= ITEM_W'(1);
         r_moved <= 1'b0;
         r_c     <= 1'b0;
         r_l     <= 1'b0;
         r_r     <= 1'b0;
         r_move  <= 1'b0;
      end else begin
         r_c     <= (w_win == EV_C);
         r_l     <= (w_win == EV_L);
         r_r     <= (w_win == EV_R);
         r_moved <= (w_win == EV_U) || (w_win == EV_D);
         r_move  <= r_moved;
         if (w_win == EV_U)      r_item <= step_item(r_item, 1'b1, LAST_ITEM);
         else if (w_win == EV_D) r_item <= step_item(r_item, 1'b0, LAST_ITEM);
      end
   end

   assign menu_state = r_item;
   assign c_pulse    = r_c;
   assign l_pulse    = r_l;
   assign r_pulse    = r_r;
   assign move_pulse = r_move;

endmodule

// File: tb/tb_menu_nav.sv
// Bench for menu_nav: directed scenarios plus random button traffic, every cycle
// compared against a behavioural model of the button/cursor rules.
module tb_menu_nav;

   localparam int unsigned NI = 4;
   localparam int unsigned DB = 4;
   localparam int unsigned RP = 10;
   localparam int B_C = 0;
   localparam int B_L = 1;
   localparam int B_R = 2;
   localparam int B_U = 3;
   localparam int B_D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btnU = 1'b0, btnD = 1'b0, btnC = 1'b0, btnL = 1'b0, btnR = 1'b0;
   logic       active = 1'b0;
   logic [2:0] menu_state;
   logic       c_pulse, l_pulse, r_pulse, move_pulse;

   always #5 clk = ~clk;

   menu_nav #(
      .NUM_ITEMS      (NI),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_CYCLES  (RP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btnU      (btnU),
      .btnD      (btnD),
      .btnC      (btnC),
      .btnL      (btnL),
      .btnR      (btnR),
      .active    (active),
      .menu_state(menu_state),
      .c_pulse   (c_pulse),
      .l_pulse   (l_pulse),
      .r_pulse   (r_pulse),
      .move_pulse(move_pulse)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cnt_c, cnt_l, cnt_r, cnt_mv;
   int first_st, first_mv, first_c, prev_st, n_steps;
   int steps[3];
   int exp3[4] = '{2, 3, 4, 1};

   // Model state: raw delay line, last DB synchronised samples, levels, events, cursor.
   logic [4:0]  m_d1, m_sync, m_lvl, m_press;
   logic [4:0]  m_hist[$];
   int unsigned m_run;
   logic        m_rep_u, m_rep_d, m_moved, m_mv_out, m_c, m_l, m_r;
   int unsigned m_item;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   // One clock edge of the reference behaviour; raw bit order {D,U,R,L,C}.
   task automatic model_step(input logic [4:0] raw, input logic act, input logic rs);
      logic [4:0] flip, ev;
      int         win;
      bit         run, fire;
      if (rs) begin
         m_d1 = '0; m_sync = '0; m_lvl = '0; m_press = '0; m_run = 0;
         m_rep_u = 0; m_rep_d = 0; m_moved = 0; m_mv_out = 0;
         m_c = 0; m_l = 0; m_r = 0; m_item = 1;
         m_hist.delete();
         for (int i = 0; i < DB; i++) m_hist.push_back(5'd0);
         return;
      end
      m_hist.push_back(m_sync);
      void'(m_hist.pop_front());
      for (int b = 0; b < 5; b++) begin
         flip[b] = 1'b1;
         foreach (m_hist[i]) if (m_hist[i][b] == m_lvl[b]) flip[b] = 1'b0;
      end
      ev = m_press;
      ev[B_U] = m_press[B_U] | m_rep_u;
      ev[B_D] = m_press[B_D] | m_rep_d;
      if (!act) begin
         ev[B_U] = 1'b0;
         ev[B_D] = 1'b0;
      end
      if (m_moved) ev = '0;
      win = -1;
      for (int b = 4; b >= 0; b--) if (ev[b]) win = b;
      run     = act && (m_lvl[B_U] != m_lvl[B_D]);
      m_run   = run ? m_run + 1 : 0;
      fire    = run && (m_run % RP == 0);
      m_rep_u = fire && m_lvl[B_U];
      m_rep_d = fire && m_lvl[B_D];
      m_press = flip & ~m_lvl;
      m_lvl   = m_lvl ^ flip;
      m_sync  = m_d1;
      m_d1    = raw;
      m_mv_out = m_moved;
      m_c     = (win == B_C);
      m_l     = (win == B_L);
      m_r     = (win == B_R);
      m_moved = (win == B_U) || (win == B_D);
      if (win == B_U)      m_item = (m_item == 1) ? NI : m_item - 1;
      else if (win == B_D) m_item = (m_item == NI) ? 1 : m_item + 1;
   endtask

   task automatic tick();
      int n;
      @(posedge clk);
      model_step({btnD, btnU, btnR, btnL, btnC}, active, rst);
      @(negedge clk);
      check_eq("menu_state", 32'(menu_state), 32'(m_item));
      check_eq("c_pulse", 32'(c_pulse), 32'(m_c));
      check_eq("l_pulse", 32'(l_pulse), 32'(m_l));
      check_eq("r_pulse", 32'(r_pulse), 32'(m_r));
      check_eq("move_pulse", 32'(move_pulse), 32'(m_mv_out));
      n = int'(c_pulse) + int'(l_pulse) + int'(r_pulse) + int'(move_pulse);
      check_eq("one_event", 32'(n <= 1), 32'd1);
      cnt_c  += int'(c_pulse);
      cnt_l  += int'(l_pulse);
      cnt_r  += int'(r_pulse);
      cnt_mv += int'(move_pulse);
   endtask

   task automatic clr_cnt();
      cnt_c = 0; cnt_l = 0; cnt_r = 0; cnt_mv = 0;
   endtask

   task automatic set_btns(input logic [4:0] mask);
      btnC = mask[B_C]; btnL = mask[B_L]; btnR = mask[B_R]; btnU = mask[B_U]; btnD = mask[B_D];
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   // Clean press: held long enough to debounce, released before any repeat.
   task automatic press(input logic [4:0] mask);
      set_btns(mask);
      repeat (8) tick();
      set_btns(5'd0);
      repeat (10) tick();
   endtask

   initial begin
      clr_cnt();
      // Reset with buttons idle
      set_btns(5'd0);
      do_reset();
      check_eq("rst_state", 32'(menu_state), 32'd1);
      check_eq("rst_pulses", 32'(cnt_c + cnt_l + cnt_r + cnt_mv), 32'd0);
      active = 1'b1;
      repeat (4) tick();

      // Bouncing btnD then stable hold: one step, latency 7 / 8
      clr_cnt();
      for (int i = 0; i < 3; i++) begin
         btnD = 1'b1; repeat (2) tick();
         btnD = 1'b0; repeat (2) tick();
      end
      btnD = 1'b1;
      first_st = -1; first_mv = -1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (first_st < 0 && menu_state == 3'd2) first_st = k;
         if (first_mv < 0 && move_pulse) first_mv = k;
      end
      check_eq("t2_state_lat", 32'(first_st), 32'd7);
      check_eq("t2_move_lat", 32'(first_mv), 32'd8);
      check_eq("t2_moves", 32'(cnt_mv), 32'd1);
      check_eq("t2_other", 32'(cnt_c + cnt_l + cnt_r), 32'd0);
      btnD = 1'b0;
      repeat (12) tick();

      // Down wraps 4->1, up wraps 1->4
      do_reset();
      active = 1'b1;
      for (int i = 0; i < 4; i++) begin
         press(5'b10000);
         check_eq("t3_down", 32'(menu_state), 32'(exp3[i]));
      end
      press(5'b01000);
      check_eq("t3_up_wrap", 32'(menu_state), 32'd4);

      // C and U together: C wins, U dropped
      clr_cnt();
      press(5'b01001);
      check_eq("t4_c", 32'(cnt_c), 32'd1);
      check_eq("t4_moves", 32'(cnt_mv), 32'd0);
      check_eq("t4_state", 32'(menu_state), 32'd4);

      // Hold-to-repeat: steps 10 cycles apart
      do_reset();
      active = 1'b1;
      btnD = 1'b1;
      prev_st = 1; n_steps = 0;
      steps = '{-1, -1, -1};
      for (int k = 1; k <= 28; k++) begin
         tick();
         if (int'(menu_state) != prev_st) begin
            if (n_steps < 3) steps[n_steps] = k;
            n_steps++;
            prev_st = int'(menu_state);
         end
      end
      btnD = 1'b0;
      repeat (12) tick();
      check_eq("t5_step0", 32'(steps[0]), 32'd7);
      check_eq("t5_step1", 32'(steps[1]), 32'd17);
      check_eq("t5_step2", 32'(steps[2]), 32'd27);
      check_eq("t5_nsteps", 32'(n_steps), 32'd3);
      check_eq("t5_state", 32'(menu_state), 32'd4);

      // Menu inactive: U/D ignored, C/L/R still pass; C held across reset
      active = 1'b0;
      clr_cnt();
      press(5'b01000);
      press(5'b10000);
      check_eq("t6_state", 32'(menu_state), 32'd4);
      check_eq("t6_moves", 32'(cnt_mv), 32'd0);
      press(5'b00100);
      check_eq("t6_r", 32'(cnt_r), 32'd1);
      press(5'b00010);
      check_eq("t6_l", 32'(cnt_l), 32'd1);
      btnC = 1'b1;
      repeat (10) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      clr_cnt();
      first_c = -1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (first_c < 0 && c_pulse) first_c = k;
      end
      check_eq("t6_c_lat", 32'(first_c), 32'd7);
      check_eq("t6_c_cnt", 32'(cnt_c), 32'd1);
      check_eq("t6_rst_state", 32'(menu_state), 32'd1);
      btnC = 1'b0;
      repeat (10) tick();

      // Random traffic against the model
      do_reset();
      active = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 4) btnC = ~btnC;
         if ($urandom_range(0, 99) < 4) btnL = ~btnL;
         if ($urandom_range(0, 99) < 4) btnR = ~btnR;
         if ($urandom_range(0, 99) < 3) btnU = ~btnU;
         if ($urandom_range(0, 99) < 3) btnD = ~btnD;
         if ($urandom_range(0, 199) == 0) active = ~active;
         rst = ($urandom_range(0, 999) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
